serial_sub: RTL

- Bit-serial unsigned/two's-complement subtractor: computes diff = a - b one bit per clock, LSB first.
- Pairs with the combinational full-adder cell as its inverse operation; intended for area-critical datapaths that can tolerate WIDTH-cycle latency.
- Valid/ready handshake on both input and output sides.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_sub_if.sv | 26 ++
 rtl/serial_sub_fs.sv | 14 +
 rtl/serial_sub.sv | 111 +++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared arithmetic-library package: serial FSM state encoding and width limits.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_e;

  localparam int SER_MAX_WIDTH = 64;

endpackage : arith_pkg

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  // Producer/consumer side: supplies operands and accepts results.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
endinterface : serial_sub_if

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor cell, the inverse companion of the full adder.
module fs (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  // Difference bit and borrow-out of a - b - bi.
  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end
endmodule : fs

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SER_MAX_WIDTH) begin : g_width_check
    $error("serial_sub: WIDTH out of range");
  end

  ser_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_bf;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_d_shift;

  // The single subtractor cell works on the current LSBs and the carried borrow.
  fs u_fs (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .bi (r_bf),
    .d  (w_d),
    .bo (w_bo)
  );

  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at bit 0.
  assign w_d_shift = {w_d, r_d_sr[WIDTH-1:1]};

  // Control FSM, shift datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_d_sr      <= '0;
      r_diff      <= '0;
      r_bf        <= 1'b0;
      r_borrow    <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a_sr     <= bus.a;
            r_b_sr     <= bus.b;
            r_bf       <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_d_sr <= w_d_shift;
          r_bf   <= w_bo;
          if (r_cnt == LAST_BIT) begin
            // Borrow into the MSB differing from borrow out flags signed overflow.
            r_diff      <= w_d_shift;
            r_borrow    <= w_bo;
            r_ovf       <= w_bo ^ r_bf;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;
  assign bus.ovf       = r_ovf;

endmodule : serial_sub
